// File: rtl/cp0_unit_pkg.sv
// cp0_defs: CP0 register numbers, exception codes and register field positions
package cp0_defs;
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;
    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int IM_LO    = 10;
    localparam int IM_HI    = 15;
    localparam int CAUSE_BD = 31;
endpackage

// File: rtl/cp0_unit.sv
// cp0_unit: CP0 status/cause/EPC/PRId with interrupt/exception arbitration at the M stage
module cp0_unit
    import cp0_defs::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL     = 32'h2022_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_sel,
    input  logic [4:0]  wr_sel,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic [4:0]  exc_code,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] rd_data,
    output logic        req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);
    logic [5:0]  r_im, r_ip;
    logic        r_exl, r_ie, r_bd;
    logic [4:0]  r_exc;
    logic [31:0] r_epc;
    logic        w_int_req, w_exc_req;
    logic [31:0] w_sr, w_cause, w_epc;

    // Interrupt decision uses the live lines; IP is only a delayed mirror for software.
    assign w_int_req  = r_ie & ~r_exl & |(hw_int & r_im);
    assign w_exc_req  = (exc_code != 5'd0) & ~r_exl;
    assign req        = w_int_req | w_exc_req;
    assign w_sr       = {16'b0, r_im, 8'b0, r_exl, r_ie};
    assign w_cause    = {r_bd, 15'b0, r_ip, 3'b0, r_exc, 2'b0};
    assign w_epc      = (m_bd ? m_pc - 32'd4 : m_pc) & ~32'd3;
    assign handler_pc = HANDLER_ADDR;
    assign epc_out    = r_epc;
    assign rd_data    = (rd_sel == REG_SR)    ? w_sr    :
                        (rd_sel == REG_CAUSE) ? w_cause :
                        (rd_sel == REG_EPC)   ? r_epc   :
                        (rd_sel == REG_PRID)  ? PRID_VAL : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im  <= '0;
            r_ip  <= '0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
            r_bd  <= 1'b0;
            r_exc <= '0;
            r_epc <= '0;
        end else begin
            r_ip <= hw_int;
            if (req) begin
                r_exl <= 1'b1;
                r_bd  <= m_bd;
                r_exc <= w_int_req ? EXC_INT : exc_code;
                r_epc <= w_epc;
            end else begin
                if (wr_en && wr_sel == REG_SR) begin
                    r_im  <= wr_data[IM_HI:IM_LO];
                    r_exl <= wr_data[SR_EXL];
                    r_ie  <= wr_data[SR_IE];
                end
                if (wr_en && wr_sel == REG_EPC) r_epc <= wr_data & ~32'd3;
                if (eret) r_exl <= 1'b0;
            end
        end
    end
endmodule
